// File: rtl/time_counter_hhmmss_if.sv
`default_nettype none
// ============================================================================
//  Module   : time_counter_hhmmss_if
//  Function : Tick/enable/load inputs and BCD time/status outputs of the
//             HH:MM:SS time-of-day counter.
//  Revision : 1.0 - initial release
// ============================================================================
interface time_counter_hhmmss_if;
  logic        i_tick;
  logic        i_en;
  logic        i_load;
  logic [23:0] i_load_time;
  logic [23:0] o_time;
  logic        o_sec_pulse;
  logic        o_min_pulse;
  logic        o_day_wrap;
  logic        o_load_err;

  modport slave (
    input  i_tick, i_en, i_load, i_load_time,
    output o_time, o_sec_pulse, o_min_pulse, o_day_wrap, o_load_err
  );

  modport master (
    output i_tick, i_en, i_load, i_load_time,
    input  o_time, o_sec_pulse, o_min_pulse, o_day_wrap, o_load_err
  );
endinterface
`default_nettype wire

// File: rtl/time_counter_hhmmss.sv
`default_nettype none
// ============================================================================
//  Module   : time_counter_hhmmss
//  Function : 24-hour BCD time-of-day counter advanced by rising edges of a
//             synchronised slow seconds clock, with validated time load.
//  Revision : 1.0 - initial release
// ============================================================================
module time_counter_hhmmss #(
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  time_counter_hhmmss_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [23:0]            time_q, time_d;
  logic                   sec_q, sec_d;
  logic                   min_q, min_d;
  logic                   day_q, day_d;
  logic                   err_q, err_d;

  logic [3:0] ss_u, ss_t, mm_u, mm_t, hh_u, hh_t;
  logic [3:0] ld_ss_u, ld_ss_t, ld_mm_u, ld_mm_t, ld_hh_u, ld_hh_t;
  logic       tick_edge, advance, load_ok;
  logic       c_ss_u, c_ss_t, c_mm_u, c_mm_t, day_end;

  assign ss_u = time_q[3:0];
  assign ss_t = time_q[7:4];
  assign mm_u = time_q[11:8];
  assign mm_t = time_q[15:12];
  assign hh_u = time_q[19:16];
  assign hh_t = time_q[23:20];

  assign ld_ss_u = bus.i_load_time[3:0];
  assign ld_ss_t = bus.i_load_time[7:4];
  assign ld_mm_u = bus.i_load_time[11:8];
  assign ld_mm_t = bus.i_load_time[15:12];
  assign ld_hh_u = bus.i_load_time[19:16];
  assign ld_hh_t = bus.i_load_time[23:20];

  assign tick_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign advance   = tick_edge & bus.i_en & ~bus.i_load;

  assign load_ok = (ld_hh_t <= 4'd2) && (ld_hh_u <= 4'd9) &&
                   ((ld_hh_t < 4'd2) || (ld_hh_u <= 4'd3)) &&
                   (ld_mm_t <= 4'd5) && (ld_mm_u <= 4'd9) &&
                   (ld_ss_t <= 4'd5) && (ld_ss_u <= 4'd9);

  // Ripple carries; each stage only carries when every lower digit wraps.
  assign c_ss_u  = (ss_u == 4'd9);
  assign c_ss_t  = c_ss_u && (ss_t == 4'd5);
  assign c_mm_u  = c_ss_t && (mm_u == 4'd9);
  assign c_mm_t  = c_mm_u && (mm_t == 4'd5);
  assign day_end = c_mm_t && (hh_t == 4'd2) && (hh_u == 4'd3);

  always_comb begin
    time_d = time_q;
    sec_d  = 1'b0;
    min_d  = 1'b0;
    day_d  = 1'b0;
    err_d  = 1'b0;
    if (bus.i_load) begin
      if (load_ok) begin
        time_d = bus.i_load_time;
      end else begin
        err_d = 1'b1;
      end
    end else if (advance) begin
      sec_d = 1'b1;
      min_d = c_ss_t;
      day_d = day_end;
      time_d[3:0] = c_ss_u ? 4'd0 : ss_u + 4'd1;
      if (c_ss_u) begin
        time_d[7:4] = (ss_t == 4'd5) ? 4'd0 : ss_t + 4'd1;
      end
      if (c_ss_t) begin
        time_d[11:8] = (mm_u == 4'd9) ? 4'd0 : mm_u + 4'd1;
      end
      if (c_mm_u) begin
        time_d[15:12] = (mm_t == 4'd5) ? 4'd0 : mm_t + 4'd1;
      end
      if (c_mm_t) begin
        if (day_end) begin
          time_d[23:16] = 8'h00;
        end else if (hh_u == 4'd9) begin
          time_d[19:16] = 4'd0;
          time_d[23:20] = hh_t + 4'd1;
        end else begin
          time_d[19:16] = hh_u + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      time_q <= 24'h000000;
      sec_q  <= 1'b0;
      min_q  <= 1'b0;
      day_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_tick};
      hist_q <= sync_q[SYNC_STAGES-1];
      time_q <= time_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      day_q  <= day_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_time      = time_q;
  assign bus.o_sec_pulse = sec_q;
  assign bus.o_min_pulse = min_q;
  assign bus.o_day_wrap  = day_q;
  assign bus.o_load_err  = err_q;

endmodule
`default_nettype wire

// File: doc/time_counter_hhmmss.md
Name: time_counter_hhmmss

Overview:
- 24-hour BCD time-of-day counter that consumes the divided seconds clock from the clock divider.
- Samples that slow clock as a data signal in the fast i_clk domain and turns each rising edge into a one-second advance of HH:MM:SS.
- Provides a load path for setting the time, and rollover/status pulses.
- Outputs drive the seven-segment display stage directly, as six BCD digits.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on i_tick (legal 2..4).

Ports:
- i_clk  input  1  system clock; same clock as the divider.
- i_rst  input  1  asynchronous active-low reset.
- i_tick  input  1  divided seconds clock (o_clk of divider); asynchronous-safe level input.
- i_en  input  1  run enable; 1 = count, 0 = hold (ticks discarded).
- i_load  input  1  single-cycle load strobe.
- i_load_time  input  24  BCD {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}, 4 bits each, MSB = hh_t.
- o_time  output  24  current time, same BCD packing as i_load_time.
- o_sec_pulse  output  1  one-cycle pulse on every seconds advance.
- o_min_pulse  output  1  one-cycle pulse when seconds wrap 59->00.
- o_day_wrap  output  1  one-cycle pulse on 23:59:59->00:00:00.
- o_load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (i_rst low, async): o_time = 00:00:00, all pulses 0, synchronizer and edge-history flops 0.
- Tick detect:
  - i_tick passes through SYNC_STAGES flops, then one history flop.
  - tick_edge = sync_out & ~history.
  - With SYNC_STAGES=2, o_time updates on the 3rd rising i_clk edge after i_tick rises.
  - Falling edges of i_tick have no effect.
  - The first rising edge after reset release is counted, even if i_tick was already high.
- Advance (tick_edge & i_en & ~i_load):
  - ss_u increments. At 9 it wraps to 0 and carries to ss_t. ss_t wraps 5->0 and carries to mm_u.
  - Minutes use the same rule: mm_u 9->0, mm_t 5->0, carry to hh_u.
  - Hours: hh_u 9->0 with carry to hh_t; when hh_t=2 and hh_u=3, a carry clears both to 0.
  - All digits update in the same clock edge. No digit ever holds a non-BCD or out-of-range value.
- Pulses (registered, asserted in the cycle o_time shows the new value, 1 cycle wide):
  - o_sec_pulse asserts on every advance.
  - o_min_pulse asserts when the advance takes ss from 59 to 00.
  - o_day_wrap asserts when the advance takes 23:59:59 to 00:00:00; o_min_pulse and o_sec_pulse also assert in that cycle.
- Hold (i_en=0):
  - tick_edge is consumed (history still updates) and discarded; o_time is unchanged; no pulses.
  - Re-enabling does not replay missed ticks.
- Load (i_load=1):
  - Valid when all of: hh_t<=2, hh_u<=9, (hh_t<2 or hh_u<=3), mm_t<=5, mm_u<=9, ss_t<=5, ss_u<=9.
  - Valid load: o_time = i_load_time on the next edge; no status pulses; o_load_err=0.
  - Invalid load: o_time is unchanged and o_load_err pulses for one cycle.
  - Load accepted regardless of i_en.
- Simultaneous load and tick_edge:
  - Load has priority; that tick is discarded, even if the load is rejected.
  - No o_sec_pulse in that cycle.
- Back-to-back loads: each is evaluated independently, one per cycle.
- Reset mid-operation: immediate return to reset state, including mid-pulse. A pending tick edge in the synchronizer is lost.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset then 3 i_tick rising edges (i_en=1) -> o_time 00:00:03; o_sec_pulse asserted 3 times; each update 3 i_clk cycles after the i_tick rise.
- Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00; o_day_wrap, o_min_pulse and o_sec_pulse all high in the final update cycle only.
- Load 00:09:59, then 1 tick -> 00:10:00 with o_min_pulse=1; load 09:59:59, then 1 tick -> 10:00:00.
- Load 24:00:00, then 12:60:00, then 1A:00:00 -> o_load_err pulses each time; o_time keeps its prior value.
- i_en=0 with 5 ticks -> o_time and pulses unchanged; set i_en=1 plus 1 tick -> +1 second only.
- i_load asserted (12:34:56) in the same cycle as tick_edge -> o_time=12:34:56, no o_sec_pulse; assert i_rst mid-count -> o_time 00:00:00 immediately, without waiting for a clock edge.
